// File: rtl/flit_rr_arbiter_if.sv
// Flit arbiter bus: input FIFO heads/read strobes, downstream valid/ready link and status.
// master = arbiter side, slave = FIFO/downstream side.
interface flit_rr_arbiter_if #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned W    = 16
);
    logic [N_IN-1:0]   fifo_empty;
    logic [N_IN*W-1:0] fifo_data;
    logic [N_IN-1:0]   fifo_read;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_IN-1:0]   grant;
    logic              busy;
    logic              err_flit;
    logic              timeout_pulse;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read, out_data, out_valid, grant, busy, err_flit, timeout_pulse
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read, out_data, out_valid, grant, busy, err_flit, timeout_pulse
    );
endinterface

// File: rtl/flit_rr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one output among N_IN FWFT flit FIFOs.
// Define FLIT_ARB_TIMEOUT_EN to add a stall counter that force-unlocks a stuck owner.
module flit_rr_arbiter #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    flit_rr_arbiter_if.master bus
);
    localparam int unsigned   PW       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_IN - 1);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [N_IN-1:0] grant_q;
    logic            err_q;

    logic [N_IN-1:0] req;
    logic [N_IN-1:0] bad;
    logic [W-1:0]    head_flit;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_next;
    int unsigned     scan_idx;
    logic [W-1:0]    owner_data;
    logic            owner_empty;
    logic            xfer;
    logic            is_end;

    if (N_IN < 2 || N_IN > 8 || W < 3 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_param_check
        $error("flit_rr_arbiter: parameter out of range");
    end

    // A non-empty input requests only if its head is HEAD/SINGLE (type MSB set).
    always_comb begin
        req       = '0;
        bad       = '0;
        head_flit = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            head_flit = bus.fifo_data[i*W +: W];
            if (!bus.fifo_empty[i]) begin
                if (head_flit[W-1]) req[i] = 1'b1;
                else                bad[i] = 1'b1;
            end
        end
    end

    // First requester at or after ptr, wrapping explicitly at N_IN.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < int'(N_IN); k++) begin
            scan_idx = 32'(ptr) + 32'(k);
            if (scan_idx >= N_IN) scan_idx = scan_idx - N_IN;
            if (!win_found && req[PW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(scan_idx);
            end
        end
        ptr_next = (win_idx == LAST_IDX) ? '0 : PW'(win_idx + 1'b1);
    end

    always_comb begin
        owner_data  = '0;
        owner_empty = 1'b1;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (owner == PW'(i)) begin
                owner_data  = bus.fifo_data[i*W +: W];
                owner_empty = bus.fifo_empty[i];
            end
        end
    end

    assign xfer   = (state == S_LOCK) && !owner_empty && bus.out_ready;
    assign is_end = owner_data[W-2];

    // Zero-latency data path while locked; output quiet and zeroed in IDLE.
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.fifo_read = '0;
        if (state == S_LOCK) begin
            bus.out_data  = owner_data;
            bus.out_valid = !owner_empty;
            if (xfer) bus.fifo_read[owner] = 1'b1;
        end
    end

`ifdef FLIT_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);
    logic [7:0] stall;
    logic       tpulse_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
`ifdef FLIT_ARB_TIMEOUT_EN
            stall    <= '0;
            tpulse_q <= 1'b0;
`endif
        end else begin
`ifdef FLIT_ARB_TIMEOUT_EN
            tpulse_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|bad) err_q <= 1'b1;
                    if (win_found) begin
                        state   <= S_LOCK;
                        owner   <= win_idx;
                        grant_q <= N_IN'(1) << win_idx;
                        ptr     <= ptr_next;
                    end
                end
                S_LOCK: begin
`ifdef FLIT_ARB_TIMEOUT_EN
                    if (xfer) begin
                        stall <= '0;
                        if (is_end) begin
                            state   <= S_IDLE;
                            grant_q <= '0;
                        end
                    end else if (stall == STALL_MAX) begin
                        stall    <= '0;
                        state    <= S_IDLE;
                        grant_q  <= '0;
                        tpulse_q <= 1'b1;
                    end else begin
                        stall <= stall + 8'd1;
                    end
`else
                    if (xfer && is_end) begin
                        state   <= S_IDLE;
                        grant_q <= '0;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state == S_LOCK);
    assign bus.err_flit = err_q;
`ifdef FLIT_ARB_TIMEOUT_EN
    assign bus.timeout_pulse = tpulse_q;
`else
    assign bus.timeout_pulse = 1'b0;
`endif
endmodule
